// File: rtl/if_pkg.sv
// Shared constants and payload types for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] BUBBLE_PC4 = 32'hffff_ff00;
    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    localparam logic [ENTRY_W-1:0] BUBBLE_ENTRY = {BUBBLE_PC4, NOP_INST};

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory req/gnt/rvalid handshake between fetch stage and memory.
interface if_fetch_if;
    import if_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry shifting FIFO; slot 0 is always the head, so head is a plain flop
// that rests at EMPTY_VAL whenever the FIFO holds nothing.
module fetch_fifo #(
    parameter int unsigned    W         = 32,
    parameter logic [W-1:0]   EMPTY_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         not_empty
);

    logic [W-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
    logic [1:0]   count_q, count_d, kept;
    logic         do_pop;

    // Remove head first, then append; flush discards any same-cycle push.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        kept    = count_q;
        do_pop  = pop && (count_q != 2'd0);
        if (flush) begin
            count_d = 2'd0;
            slot0_d = EMPTY_VAL;
        end else begin
            if (do_pop) begin
                slot0_d = slot1_q;
                kept    = count_q - 2'd1;
            end
            if (push) begin
                if (kept == 2'd0) slot0_d = push_data;
                else              slot1_d = push_data;
            end
            count_d = kept + {1'b0, push};
            if (count_d == 2'd0) slot0_d = EMPTY_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q   <= EMPTY_VAL;
            slot1_q   <= '0;
            count_q   <= 2'd0;
            not_empty <= 1'b0;
        end else begin
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            count_q   <= count_d;
            not_empty <= (count_d != 2'd0);
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && (kept == 2'd2)));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues imem requests, buffers responses
// in a 2-entry queue and handles load-use stalls and branch redirects.
module if_fetch
    import if_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipeline_stop_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    if_fetch_if.master       imem,
    output logic [XLEN-1:0]  if_pc4_o,
    output logic [XLEN-1:0]  if_inst_o,
    output logic             if_valid_o
);

    logic [XLEN-1:0]    pc_q;
    logic [1:0]         kill_q, kill_d;
    logic               run_q;
    logic               q_pop, q_push, grant;
    logic [1:0]         q_count, outstanding;
    logic [2:0]         committed;
    logic [XLEN-1:0]    inflight_addr;
    logic               inflight_valid;
    logic [ENTRY_W-1:0] q_head;
    fetch_entry_t       head_e, push_e;

    // Issue credit counts the slot freed by this cycle's pop, giving 1 inst/cycle.
    always_comb begin
        q_pop           = if_valid_o && !pipeline_stop_i && !branch_taken_i;
        committed       = 3'(q_count) - 3'(q_pop) + 3'(outstanding);
        imem.imem_req_o = run_q && !branch_taken_i && (committed < 3'd2);
        grant           = imem.imem_req_o && imem.imem_gnt_i;
        q_push          = imem.imem_rvalid_i && (kill_q == 2'd0);
        push_e.pc4      = inflight_addr + 32'd4;
        push_e.inst     = imem.imem_rdata_i;
        kill_d          = kill_q;
        if (branch_taken_i)
            kill_d = outstanding - 2'(imem.imem_rvalid_i);
        else if (imem.imem_rvalid_i && (kill_q != 2'd0))
            kill_d = kill_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            kill_q <= 2'd0;
            run_q  <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            kill_q <= kill_d;
            if (branch_taken_i) pc_q <= branch_target_i;
            else if (grant)     pc_q <= pc_q + 32'd4;
        end
    end

    assign imem.imem_addr_o = pc_q;

    fetch_fifo #(
        .W         (ENTRY_W),
        .EMPTY_VAL (BUBBLE_ENTRY)
    ) u_inst_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (push_e),
        .pop       (q_pop),
        .flush     (branch_taken_i),
        .head      (q_head),
        .count     (q_count),
        .not_empty (if_valid_o)
    );

    // Addresses of granted requests awaiting their response; depth = outstanding.
    fetch_fifo #(
        .W         (XLEN),
        .EMPTY_VAL (RESET_PC)
    ) u_addr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (pc_q),
        .pop       (imem.imem_rvalid_i),
        .flush     (1'b0),
        .head      (inflight_addr),
        .count     (outstanding),
        .not_empty (inflight_valid)
    );

    assign head_e    = q_head;
    assign if_pc4_o  = head_e.pc4;
    assign if_inst_o = head_e.inst;

    rvalid_has_grant: assert property (@(posedge clk) disable iff (!rst_n)
        imem.imem_rvalid_i |-> inflight_valid);

endmodule

// File: tb/tb_if_fetch.sv
// Randomised bench for if_fetch: memory model plus a queue-level reference of
// the fetch stream, with directed phases for reset, stall and redirect timing.
module tb_if_fetch;
    import if_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        stop  = 1'b0;
    logic        br    = 1'b0;
    logic [31:0] tgt   = 32'h0;
    logic [31:0] pc4, inst;
    logic        valid;

    if_fetch_if bus();

    if_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pipeline_stop_i (stop),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .imem            (bus),
        .if_pc4_o        (pc4),
        .if_inst_o       (inst),
        .if_valid_o      (valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int ready; } req_t;
    typedef struct { logic [31:0] pc4; logic [31:0] inst; } ent_t;

    req_t        pend[$];
    ent_t        fq[$];
    int          vectors = 0, errors = 0, cyc = 0, epoch = 0, grants = 0;
    logic [31:0] exp_pc = RESET_PC;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100, stop_pct = 0, br_pct = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic b, input logic [31:0] t, input logic s);
        int   pop;
        logic exp_req, g, rv;
        req_t r;
        ent_t e;
        check("valid", 32'(valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check("pc4", pc4, fq[0].pc4);
            check("inst", inst, fq[0].inst);
        end else begin
            check("bubble_pc4", pc4, BUBBLE_PC4);
            check("bubble_inst", inst, NOP_INST);
        end
        stop = s; br = b; tgt = t;
        rv = (pend.size() != 0) && (pend[0].ready <= cyc);
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
        bus.imem_gnt_i    = 1'b0;
        #1;
        pop     = (fq.size() != 0 && !s && !b) ? 1 : 0;
        exp_req = !b && ((fq.size() - pop + pend.size()) < 2);
        check("req", 32'(bus.imem_req_o), 32'(exp_req));
        check("addr", bus.imem_addr_o, exp_pc);
        g = bus.imem_req_o && (int'($urandom_range(99)) < gnt_pct);
        bus.imem_gnt_i = g;
        if (pop != 0) void'(fq.pop_front());
        if (rv) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !b) begin
                e.pc4  = r.addr + 32'd4;
                e.inst = mem_word(r.addr);
                fq.push_back(e);
            end
        end
        if (g) begin
            r.addr  = exp_pc;
            r.epoch = epoch;
            r.ready = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(r);
            exp_pc += 32'd4;
            grants++;
        end
        if (b) begin
            fq.delete();
            epoch++;
            exp_pc = t;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_step();
        logic [31:0] t;
        t = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
        step(int'($urandom_range(99)) < br_pct, t, int'($urandom_range(99)) < stop_pct);
    endtask

    // Asynchronous reset checked mid-cycle; leaves the bench at the first request cycle.
    task automatic do_reset();
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        stop = 1'b0; br = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_pc4", pc4, BUBBLE_PC4);
        check("rst_inst", inst, NOP_INST);
        check("rst_req", 32'(bus.imem_req_o), 32'h0);
        check("rst_addr", bus.imem_addr_o, RESET_PC);
        pend.delete(); fq.delete(); epoch++; exp_pc = RESET_PC;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); cyc++;
        @(negedge clk);
    endtask

    initial begin
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        @(negedge clk);
        do_reset();

        // Back-to-back fetch with single-cycle memory; cycle 1 is the first request.
        for (int k = 1; k <= 10; k++) begin
            if (k >= 3) begin
                check("thru_valid", 32'(valid), 32'h1);
                check("thru_pc4", pc4, 32'(4 * (k - 2)));
            end
            step(1'b0, 32'h0, 1'b0);
        end

        // Redirect latency: target+4 visible three cycles after the branch.
        step(1'b1, 32'h100, 1'b0);
        check("br_bubble", pc4, BUBBLE_PC4);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check("br_pc4_first", pc4, 32'h104);
        step(1'b0, 32'h0, 1'b0);
        check("br_pc4_second", pc4, 32'h108);

        // Branch together with stop still flushes.
        step(1'b1, 32'h200, 1'b1);
        check("brstop_pc4", pc4, BUBBLE_PC4);
        check("brstop_inst", inst, NOP_INST);
        repeat (4) step(1'b0, 32'h0, 1'b0);

        // Stall with head pc4=8 for three cycles.
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0);
        check("stall_head", pc4, 32'h8);
        grants = 0;
        repeat (3) step(1'b0, 32'h0, 1'b1);
        check("stall_hold", pc4, 32'h8);
        check("stall_grants", 32'(grants > 2), 32'h0);
        repeat (6) step(1'b0, 32'h0, 1'b0);

        // Slow memory: 3-cycle latency, grant withheld for two cycles.
        lat_min = 3; lat_max = 3; gnt_pct = 0;
        repeat (2) step(1'b0, 32'h0, 1'b0);
        gnt_pct = 100;
        repeat (12) step(1'b0, 32'h0, 1'b0);

        // Random mix of latency, grant gaps, stalls and redirects.
        lat_min = 1; lat_max = 3; gnt_pct = 60; stop_pct = 30; br_pct = 8;
        repeat (3000) rand_step();

        // Reset with a response still outstanding.
        stop_pct = 0; br_pct = 0; gnt_pct = 100;
        for (int i = 0; i < 20 && pend.size() == 0; i++) rand_step();
        check("midrst_outstanding", 32'(pend.size() != 0), 32'h1);
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
